mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port line-fill / write arbiter in front of a fixed-latency pipelined memory.
// The data side has fixed priority; fills overlap issue and return for BURST+LAT cycles.
module mem_arbiter #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ireq,
  input  logic [15:0]              iaddr,
  input  logic                     dreq,
  input  logic                     dwr,
  input  logic [15:0]              daddr,
  input  logic [15:0]              dwdata,
  input  logic [15:0]              mem_rdata,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  output logic [15:0]              fill_data,
  output logic [$clog2(BURST)-1:0] fill_idx,
  output logic                     i_fill_valid,
  output logic                     d_fill_valid,
  output logic                     i_done,
  output logic                     d_done
);

  localparam int unsigned IW = $clog2(BURST);
  localparam int unsigned CW = $clog2(BURST + LAT);
  localparam logic [CW-1:0] C_BURST = CW'(BURST);
  localparam logic [CW-1:0] C_LAT   = CW'(LAT);
  localparam logic [CW-1:0] C_LAST  = CW'(BURST + LAT - 1);
  localparam logic [15:0]   LINE_MASK = ~16'((1 << (IW + 1)) - 1);

  typedef enum logic [1:0] {S_IDLE, S_IFILL, S_DFILL, S_DWRITE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cyc;
  logic [15:0]   r_base;
  logic [15:0]   r_wdata;

  logic w_fill;
  logic w_issue;
  logic w_ret;
  logic w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_base  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cyc <= '0;
          if (dreq && dwr) begin
            r_state <= S_DWRITE;
            r_base  <= daddr & 16'hFFFE;
            r_wdata <= dwdata;
          end else if (dreq) begin
            r_state <= S_DFILL;
            r_base  <= daddr & LINE_MASK;
          end else if (ireq) begin
            r_state <= S_IFILL;
            r_base  <= iaddr & LINE_MASK;
          end
        end
        S_IFILL, S_DFILL: begin
          if (r_cyc == C_LAST) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        S_DWRITE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state and counter; the issue and return
  // windows overlap whenever LAT < BURST.
  always_comb begin
    w_fill  = (r_state == S_IFILL) || (r_state == S_DFILL);
    w_issue = w_fill && (r_cyc < C_BURST);
    w_ret   = w_fill && (r_cyc >= C_LAT);
    w_last  = w_fill && (r_cyc == C_LAST);

    mem_enable   = w_issue || (r_state == S_DWRITE);
    mem_wr       = (r_state == S_DWRITE);
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_idx     = '0;
    i_fill_valid = w_ret && (r_state == S_IFILL);
    d_fill_valid = w_ret && (r_state == S_DFILL);
    i_done       = w_last && (r_state == S_IFILL);
    d_done       = (w_last && (r_state == S_DFILL)) || (r_state == S_DWRITE);

    if (w_issue) begin
      mem_addr = r_base + (16'(r_cyc) << 1);
    end else if (r_state == S_DWRITE) begin
      mem_addr  = r_base;
      mem_wdata = r_wdata;
    end

    if (w_ret) begin
      fill_data = mem_rdata;
      fill_idx  = IW'(r_cyc - C_LAT);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LAT=4, BURST=8) with a behavioural pipelined
// memory returning (address ^ 16'hA5A5) LAT cycles after each read issue.
module tb_mem_arbiter;

  localparam int unsigned L = 4;
  localparam int unsigned B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0;
  logic [15:0] iaddr = '0;
  logic        dreq = 1'b0;
  logic        dwr = 1'b0;
  logic [15:0] daddr = '0;
  logic [15:0] dwdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic        i_done;
  logic        d_done;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [15:0] pipe [L];
  logic [56:0] w_obs;

  mem_arbiter #(.LAT(4), .BURST(8)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr),
    .dreq(dreq), .dwr(dwr), .daddr(daddr), .dwdata(dwdata),
    .mem_rdata(mem_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= (mem_enable && !mem_wr) ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[L-1];

  assign w_obs = {mem_enable, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
                  i_fill_valid, d_fill_valid, i_done, d_done};

  function automatic logic [56:0] ev(input logic en, input logic wr,
                                     input logic [15:0] addr, input logic [15:0] wd,
                                     input logic [15:0] fd, input logic [2:0] idx,
                                     input logic iv, input logic dv,
                                     input logic id, input logic dd);
    return {en, wr, addr, wd, fd, idx, iv, dv, id, dd};
  endfunction

  task automatic chk(input string tag, input logic [56:0] exp);
    n_total++;
    assert (w_obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, '0);
  endtask

  // Checks ncyc cycles of a fill whose request was driven just before the call.
  task automatic run_fill(input string tag, input logic is_i, input logic [15:0] base,
                          input int ncyc, input logic drop, input logic scr);
    logic        en, v, dn;
    logic [15:0] a, fd;
    logic [2:0]  idx;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      en  = (k < B);
      a   = en ? base + 16'(2 * k) : 16'h0000;
      v   = (k >= L);
      fd  = v ? ((base + 16'(2 * (k - L))) ^ 16'hA5A5) : 16'h0000;
      idx = v ? 3'(k - L) : 3'd0;
      dn  = (k == B + L - 1);
      chk($sformatf("%s_c%0d", tag, k),
          ev(en, 1'b0, a, 16'h0000, fd, idx, v && is_i, v && !is_i, dn && is_i, dn && !is_i));
      if (scr && k == 2) begin
        iaddr = 16'h0124;
        daddr = 16'h7777;
        dwr   = 1'b1;
        dreq  = 1'b1;
      end
      if (drop && k == B + L - 1) begin
        if (is_i) ireq = 1'b0;
        else      dreq = 1'b0;
        if (scr)  dreq = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_hold", '0);
    rst = 1'b0;
    idle_chk("reset_release");

    // Basic instruction fill: 0x1236 -> line base 0x1230
    ireq = 1'b1; iaddr = 16'h1236;
    run_fill("ifill", 1'b1, 16'h1230, 12, 1'b1, 1'b0);
    idle_chk("ifill_idle");
    idle_chk("ifill_idle2");

    // Simultaneous requests: data side wins, instruction follows after one IDLE cycle
    ireq = 1'b1; iaddr = 16'h2000;
    dreq = 1'b1; dwr = 1'b0; daddr = 16'h0040;
    run_fill("prio_d", 1'b0, 16'h0040, 12, 1'b1, 1'b0);
    idle_chk("prio_gap");
    run_fill("prio_i", 1'b1, 16'h2000, 12, 1'b1, 1'b0);
    idle_chk("prio_idle");

    // Single-word write
    dreq = 1'b1; dwr = 1'b1; daddr = 16'h00A3; dwdata = 16'hBEEF;
    @(negedge clk);
    chk("dwrite", ev(1'b1, 1'b1, 16'h00A2, 16'hBEEF, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    dreq = 1'b0; dwr = 1'b0; dwdata = 16'h0;
    idle_chk("dwrite_idle");
    idle_chk("dwrite_idle2");

    // Top-of-memory line, with request changes mid-fill that must be ignored
    ireq = 1'b1; iaddr = 16'hFFF8;
    run_fill("wrap", 1'b1, 16'hFFF0, 12, 1'b1, 1'b1);
    dwr = 1'b0;
    idle_chk("wrap_idle");
    idle_chk("wrap_idle2");

    // Reset aborts a fill at cyc=6 and beats a pending request
    ireq = 1'b1; iaddr = 16'h3456;
    run_fill("abort", 1'b1, 16'h3450, 7, 1'b0, 1'b0);
    rst = 1'b1;
    idle_chk("abort_rst");
    rst = 1'b0; ireq = 1'b0;
    for (int k = 0; k < 8; k++) idle_chk($sformatf("abort_quiet%0d", k));
    ireq = 1'b1;
    run_fill("after_abort", 1'b1, 16'h3450, 12, 1'b1, 1'b0);
    idle_chk("after_abort_idle");

    // Request held through done: back-to-back fills with a new address
    ireq = 1'b1; iaddr = 16'h4000;
    run_fill("b2b_1", 1'b1, 16'h4000, 12, 1'b0, 1'b0);
    iaddr = 16'h5008;
    idle_chk("b2b_gap");
    run_fill("b2b_2", 1'b1, 16'h5000, 12, 1'b1, 1'b0);
    idle_chk("b2b_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
